// File: rtl/md5_step_sched.sv
// md5_step_sched: gathers one 512-bit MD5 block as 16 serial words and runs
// the 64 compression steps through md5_core, one step per clock. After the
// last step it adds the working words into the chaining value and publishes
// the digest. o_hash is {A,B,C,D} with A in the most-significant word.

// md5_core: one combinational MD5 step; returns the new B word.
module md5_core (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  input  logic [31:0] i_m,
  input  logic [31:0] i_t,
  input  logic [4:0]  i_s,
  input  logic [1:0]  i_round,
  output logic [31:0] o_a
);
  logic [31:0] w_f;
  logic [31:0] w_sum;
  logic [63:0] w_dbl;

  // Round function, pre-rotate sum, then rotate left by i_s via a doubled word.
  always_comb begin
    w_f = 32'd0;
    case (i_round)
      2'd0:    w_f = (i_b & i_c) | (~i_b & i_d);
      2'd1:    w_f = (i_d & i_b) | (~i_d & i_c);
      2'd2:    w_f = i_b ^ i_c ^ i_d;
      default: w_f = i_c ^ (i_b | ~i_d);
    endcase
    w_sum = i_a + w_f + i_m + i_t;
    w_dbl = {w_sum, w_sum} << i_s;
    o_a   = i_b + w_dbl[63:32];
  end
endmodule

module md5_step_sched #(
  parameter logic [31:0] IV_A = 32'h67452301,
  parameter logic [31:0] IV_B = 32'hefcdab89,
  parameter logic [31:0] IV_C = 32'h98badcfe,
  parameter logic [31:0] IV_D = 32'h10325476
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_init,
  input  logic          i_rdy,
  input  logic [31:0]   i_msg,
  output logic [127:0]  o_hash,
  output logic          o_rdy,
  output logic          o_busy
);
  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_FINAL} state_t;

  localparam logic [31:0] K_TABLE [0:63] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  state_t      r_state;
  state_t      w_stateNext;
  logic [3:0]  r_wordCnt;
  logic [5:0]  r_step;
  logic [31:0] r_msgMem [16];
  logic [31:0] r_chainA, r_chainB, r_chainC, r_chainD;
  logic [31:0] r_a, r_b, r_c, r_d;

  logic        w_accept;
  logic [3:0]  w_g;
  logic [4:0]  w_s;
  logic [31:0] w_t;
  logic [31:0] w_aNew;
  logic [31:0] w_sumA, w_sumB, w_sumC, w_sumD;

  assign w_accept = (r_state == ST_LOAD) && i_rdy;
  assign w_t      = K_TABLE[r_step];
  assign w_sumA   = r_chainA + r_a;
  assign w_sumB   = r_chainB + r_b;
  assign w_sumC   = r_chainC + r_c;
  assign w_sumD   = r_chainD + r_d;

  // Message word index and rotate amount for the current step.
  always_comb begin
    w_g = r_step[3:0];
    case (r_step[5:4])
      2'd0:    w_g = r_step[3:0];
      2'd1:    w_g = r_step[3:0] * 4'd5 + 4'd1;
      2'd2:    w_g = r_step[3:0] * 4'd3 + 4'd5;
      default: w_g = r_step[3:0] * 4'd7;
    endcase
    w_s = 5'd7;
    case ({r_step[5:4], r_step[1:0]})
      4'b0000: w_s = 5'd7;   4'b0001: w_s = 5'd12;
      4'b0010: w_s = 5'd17;  4'b0011: w_s = 5'd22;
      4'b0100: w_s = 5'd5;   4'b0101: w_s = 5'd9;
      4'b0110: w_s = 5'd14;  4'b0111: w_s = 5'd20;
      4'b1000: w_s = 5'd4;   4'b1001: w_s = 5'd11;
      4'b1010: w_s = 5'd16;  4'b1011: w_s = 5'd23;
      4'b1100: w_s = 5'd6;   4'b1101: w_s = 5'd10;
      4'b1110: w_s = 5'd15;  default: w_s = 5'd21;
    endcase
  end

  md5_core u_core (
    .i_a     (r_a),
    .i_b     (r_b),
    .i_c     (r_c),
    .i_d     (r_d),
    .i_m     (r_msgMem[w_g]),
    .i_t     (w_t),
    .i_s     (w_s),
    .i_round (r_step[5:4]),
    .o_a     (w_aNew)
  );

  // State register; reset aborts any partial block or run.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_LOAD;
    else          r_state <= w_stateNext;
  end

  // Next state: 16th word starts the run, step 63 ends it, FINAL lasts one cycle.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_LOAD:  if (w_accept && (r_wordCnt == 4'd15)) w_stateNext = ST_RUN;
      ST_RUN:   if (r_step == 6'd63) w_stateNext = ST_FINAL;
      ST_FINAL: w_stateNext = ST_LOAD;
      default:  w_stateNext = ST_LOAD;
    endcase
  end

  // Message word storage; contents are only meaningful once 16 words are in.
  always_ff @(posedge i_clk) begin
    if (w_accept) r_msgMem[r_wordCnt] <= i_msg;
  end

  // Counters, chaining/working words and the registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wordCnt <= 4'd0;
      r_step    <= 6'd0;
      r_chainA  <= IV_A;
      r_chainB  <= IV_B;
      r_chainC  <= IV_C;
      r_chainD  <= IV_D;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_c       <= 32'd0;
      r_d       <= 32'd0;
      o_hash    <= 128'd0;
      o_rdy     <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      o_rdy <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            if ((r_wordCnt == 4'd0) && i_init) begin
              r_chainA <= IV_A;
              r_chainB <= IV_B;
              r_chainC <= IV_C;
              r_chainD <= IV_D;
            end
            if (r_wordCnt == 4'd15) begin
              r_a       <= r_chainA;
              r_b       <= r_chainB;
              r_c       <= r_chainC;
              r_d       <= r_chainD;
              r_wordCnt <= 4'd0;
              r_step    <= 6'd0;
              o_busy    <= 1'b1;
            end else begin
              r_wordCnt <= r_wordCnt + 4'd1;
            end
          end
        end
        ST_RUN: begin
          r_a    <= r_d;
          r_b    <= w_aNew;
          r_c    <= r_b;
          r_d    <= r_c;
          r_step <= (r_step == 6'd63) ? 6'd0 : r_step + 6'd1;
        end
        ST_FINAL: begin
          r_chainA <= w_sumA;
          r_chainB <= w_sumB;
          r_chainC <= w_sumC;
          r_chainD <= w_sumD;
          o_hash   <= {w_sumA, w_sumB, w_sumC, w_sumD};
          o_rdy    <= 1'b1;
          o_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_md5_step_sched.sv
// tb_md5_step_sched: table of whole-block vectors plus hand-written sequences
// for dropped words, mid-block/mid-run reset and gapped loading.
module tb_md5_step_sched;
  localparam logic [127:0] IV_HASH    = 128'h67452301_efcdab89_98badcfe_10325476;
  localparam logic [127:0] EMPTY_HASH = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;
  localparam logic [127:0] ABC_HASH   = 128'h98500190_b04fd23c_7d3f96d6_727fe128;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_init;
  logic         i_rdy;
  logic [31:0]  i_msg;
  logic [127:0] o_hash;
  logic         o_rdy;
  logic         o_busy;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] kTab [64];
  int shTab [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};

  typedef struct {
    string        name;
    bit           init;
    logic [511:0] blk;
    logic [127:0] expHash;
  } vec_t;
  vec_t vecs [7];

  md5_step_sched dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_init  (i_init),
    .i_rdy   (i_rdy),
    .i_msg   (i_msg),
    .o_hash  (o_hash),
    .o_rdy   (o_rdy),
    .o_busy  (o_busy)
  );

  // Free-running clock.
  always #5 i_clk = ~i_clk;

  // Reference K table built from its sine definition.
  task automatic buildK();
    real v;
    for (int i = 0; i < 64; i++) begin
      v = $sin(real'(i + 1));
      if (v < 0.0) v = -v;
      kTab[i] = 32'(longint'($floor(v * 4294967296.0)));
    end
  endtask

  // Textbook MD5 compression of one block onto a {A,B,C,D} chaining value.
  function automatic logic [127:0] md5Ref(input logic [127:0] chain, input logic [511:0] blk);
    logic [31:0] a, b, c, d, f, x, tmp;
    int g, sh;
    a = chain[127:96]; b = chain[95:64]; c = chain[63:32]; d = chain[31:0];
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i; end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7 * i) % 16; end
      sh  = shTab[i / 16][i % 4];
      x   = a + f + kTab[i] + blk[g * 32 +: 32];
      tmp = d;
      d   = c;
      c   = b;
      b   = b + ((x << sh) | (x >> (32 - sh)));
      a   = tmp;
    end
    return {chain[127:96] + a, chain[95:64] + b, chain[63:32] + c, chain[31:0] + d};
  endfunction

  task automatic setVec(input int idx, input string name, input bit init,
                        input logic [511:0] blk, input logic [127:0] expHash);
    vecs[idx].name    = name;
    vecs[idx].init    = init;
    vecs[idx].blk     = blk;
    vecs[idx].expHash = expHash;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Load nWords of blk, optionally with random idle cycles between words.
  task automatic applyStimulus(input bit init, input logic [511:0] blk, input int nWords, input bit gapped);
    for (int k = 0; k < nWords; k++) begin
      if (gapped) repeat ($urandom_range(0, 3)) begin @(posedge i_clk); #1; end
      i_rdy  = 1'b1;
      i_init = init && (k == 0);
      i_msg  = blk[k * 32 +: 32];
      @(posedge i_clk); #1;
      i_rdy  = 1'b0;
      i_init = 1'b0;
    end
  endtask

  // Called just after the 16th-word edge; checks latency, busy length and digest.
  task automatic waitResult(input string name, input logic [127:0] expHash, input bit junk);
    int  lat;
    int  busyCnt;
    bit  seen;
    lat = 0; seen = 1'b0;
    busyCnt = o_busy ? 1 : 0;
    if (junk) begin i_rdy = 1'b1; i_init = 1'b1; i_msg = $urandom(); end
    for (int k = 1; k <= 150 && !seen; k++) begin
      @(posedge i_clk); #1;
      if (o_busy) busyCnt++;
      if (o_rdy) begin
        seen = 1'b1;
        lat  = k;
        i_rdy = 1'b0; i_init = 1'b0;
      end else if (junk) begin
        i_rdy  = 1'($urandom_range(0, 1));
        i_init = 1'($urandom_range(0, 1));
        i_msg  = $urandom();
      end
    end
    i_rdy = 1'b0; i_init = 1'b0;
    checkOutput({name, ".latency"}, 128'(lat), 128'd65);
    checkOutput({name, ".busyCycles"}, 128'(busyCnt), 128'd65);
    checkOutput({name, ".hash"}, o_hash, expHash);
  endtask

  // Assert reset asynchronously, check cleared outputs, then confirm no stray pulse.
  task automatic applyReset(input string name);
    int pulses;
    i_rst_n = 1'b0;
    #1;
    checkOutput({name, ".hash"}, o_hash, 128'd0);
    checkOutput({name, ".flags"}, 128'({o_busy, o_rdy}), 128'd0);
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge i_clk); #1;
      if (o_rdy || o_busy) pulses++;
    end
    checkOutput({name, ".noPulse"}, 128'(pulses), 128'd0);
  endtask

  initial begin
    logic [511:0] emptyBlk;
    logic [511:0] abcBlk;
    logic [511:0] rndBlk;
    logic [127:0] rndHash;

    i_rst_n = 1'b0; i_init = 1'b0; i_rdy = 1'b0; i_msg = 32'd0;
    buildK();

    emptyBlk = '0;
    emptyBlk[31:0] = 32'h00000080;
    abcBlk = '0;
    abcBlk[31:0] = 32'h80636261;
    abcBlk[14 * 32 +: 32] = 32'h00000018;
    for (int k = 0; k < 16; k++) rndBlk[k * 32 +: 32] = $urandom();
    rndHash = md5Ref(IV_HASH, rndBlk);

    setVec(0, "emptyInit",   1'b1, emptyBlk, EMPTY_HASH);
    setVec(1, "abcInit",     1'b1, abcBlk,   ABC_HASH);
    setVec(2, "abcChained",  1'b0, abcBlk,   md5Ref(ABC_HASH, abcBlk));
    setVec(3, "abcReinit",   1'b1, abcBlk,   ABC_HASH);
    setVec(4, "rndInit",     1'b1, rndBlk,   rndHash);
    setVec(5, "rndChained",  1'b0, rndBlk,   md5Ref(rndHash, rndBlk));
    setVec(6, "emptyAgain",  1'b1, emptyBlk, EMPTY_HASH);

    #1;
    checkOutput("reset.hash", o_hash, 128'd0);
    checkOutput("reset.flags", 128'({o_busy, o_rdy}), 128'd0);
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Back-to-back blocks: each next block starts in the rdy_o cycle.
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].init, vecs[v].blk, 16, 1'b0);
      waitResult(vecs[v].name, vecs[v].expHash, 1'b0);
    end

    // Words offered while busy must be dropped without disturbing anything.
    applyStimulus(1'b1, abcBlk, 16, 1'b0);
    waitResult("dropDuringRun", ABC_HASH, 1'b1);
    @(posedge i_clk); #1;
    checkOutput("dropDuringRun.pulseWidth", 128'(o_rdy), 128'd0);
    checkOutput("dropDuringRun.hashHold", o_hash, ABC_HASH);
    applyStimulus(1'b1, emptyBlk, 16, 1'b0);
    waitResult("afterDrop", EMPTY_HASH, 1'b0);

    // Reset after word 7; next block without init must start from IV.
    applyStimulus(1'b1, emptyBlk, 7, 1'b0);
    applyReset("rstWord7");
    applyStimulus(1'b0, abcBlk, 16, 1'b0);
    waitResult("afterRstWord7", ABC_HASH, 1'b0);

    // Reset while the step counter is at 30.
    applyStimulus(1'b1, emptyBlk, 16, 1'b0);
    repeat (30) @(posedge i_clk);
    #1;
    applyReset("rstStep30");
    applyStimulus(1'b1, abcBlk, 16, 1'b0);
    waitResult("afterRstStep30", ABC_HASH, 1'b0);

    // Gapped loading gives the same digests as contiguous loading.
    applyStimulus(1'b1, abcBlk, 16, 1'b1);
    waitResult("gappedAbc", ABC_HASH, 1'b0);
    applyStimulus(1'b1, rndBlk, 16, 1'b1);
    waitResult("gappedRnd", rndHash, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
